// File: rtl/ps2_packet_decoder_if.sv
// Bundle of frame-in and packet-out signals between the PS/2 reader side and
// the packet decoder. The decoder uses the slave modport; the reader/cursor
// side (or a testbench) uses master.
interface ps2_packet_decoder_if;
  logic        word_ready;
  logic [10:0] data;
  logic        packet_valid;
  logic        btn_left;
  logic        btn_right;
  logic        btn_middle;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        x_ovf;
  logic        y_ovf;
  logic        frame_err;
  logic [7:0]  err_cnt;

  modport master (
    output word_ready, data,
    input  packet_valid, btn_left, btn_right, btn_middle, dx, dy, x_ovf, y_ovf,
    input  frame_err, err_cnt
  );

  modport slave (
    input  word_ready, data,
    output packet_valid, btn_left, btn_right, btn_middle, dx, dy, x_ovf, y_ovf,
    output frame_err, err_cnt
  );
endinterface

// File: rtl/ps2_packet_decoder.sv
// PS/2 mouse packet decoder: validates 11-bit frames, assembles three bytes
// into a packet (buttons, signed 9-bit dx/dy, overflow flags) and drops a
// partial packet after an inter-byte idle timeout.
module ps2_packet_decoder #(
  parameter int unsigned PKT_TIMEOUT = 200000,
  parameter int unsigned TO_W        = 18
) (
  input logic                 ck,
  input logic                 reset,
  ps2_packet_decoder_if.slave bus
);

  localparam logic [1:0] StWaitB0 = 2'd0;
  localparam logic [1:0] StWaitB1 = 2'd1;
  localparam logic [1:0] StWaitB2 = 2'd2;

  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(PKT_TIMEOUT);

  logic [1:0]      st_q, st_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            wr_q;
  // byte0 minus its always-one sync bit: {b7, b6, b5, b4, b2, b1, b0}
  logic [6:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic            pv_q, pv_d;
  logic            fe_q, fe_d;
  logic [7:0]      err_q, err_d;
  logic [2:0]      btn_q, btn_d;
  logic [8:0]      dx_q, dx_d;
  logic [8:0]      dy_q, dy_d;
  logic [1:0]      ovf_q, ovf_d;

  logic       accept;
  logic       frame_ok;
  logic [7:0] rx_byte;

  assign accept   = bus.word_ready & ~wr_q;
  assign frame_ok = ~bus.data[10] & bus.data[0] & (^bus.data[9:1]);

  // D0 arrives first and sits in the MSB side of the frame, so reverse it.
  always_comb begin
    rx_byte = '0;
    for (int i = 0; i < 8; i++) begin
      rx_byte[i] = bus.data[9-i];
    end
  end

  // Next-state: frame validation, packet FSM, inter-byte timeout.
  always_comb begin
    st_d  = st_q;
    to_d  = to_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    pv_d  = 1'b0;
    fe_d  = 1'b0;
    err_d = err_q;
    btn_d = btn_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    ovf_d = ovf_q;

    if (accept) begin
      // An accept takes priority over a timeout landing on the same edge.
      to_d = '0;
      if (!frame_ok) begin
        fe_d = 1'b1;
        st_d = StWaitB0;
      end else begin
        case (st_q)
          StWaitB0: begin
            if (rx_byte[3]) begin
              b0_d = {rx_byte[7:4], rx_byte[2:0]};
              st_d = StWaitB1;
            end else begin
              fe_d = 1'b1;
            end
          end
          StWaitB1: begin
            b1_d = rx_byte;
            st_d = StWaitB2;
          end
          StWaitB2: begin
            btn_d = b0_q[2:0];
            dx_d  = {b0_q[3], b1_q};
            dy_d  = {b0_q[4], rx_byte};
            ovf_d = b0_q[6:5];
            pv_d  = 1'b1;
            st_d  = StWaitB0;
          end
          default: st_d = StWaitB0;
        endcase
      end
      if (fe_d && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
    end else if (st_q != StWaitB0) begin
      if (to_q >= TimeoutVal) begin
        st_d = StWaitB0;
        to_d = '0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!reset) begin
      st_q  <= StWaitB0;
      to_q  <= '0;
      wr_q  <= 1'b0;
      b0_q  <= '0;
      b1_q  <= '0;
      pv_q  <= 1'b0;
      fe_q  <= 1'b0;
      err_q <= '0;
      btn_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      ovf_q <= '0;
    end else begin
      st_q  <= st_d;
      to_q  <= to_d;
      wr_q  <= bus.word_ready;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      pv_q  <= pv_d;
      fe_q  <= fe_d;
      err_q <= err_d;
      btn_q <= btn_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.packet_valid = pv_q;
  assign bus.frame_err    = fe_q;
  assign bus.err_cnt      = err_q;
  assign bus.btn_left     = btn_q[0];
  assign bus.btn_right    = btn_q[1];
  assign bus.btn_middle   = btn_q[2];
  assign bus.dx           = dx_q;
  assign bus.dy           = dy_q;
  assign bus.x_ovf        = ovf_q[0];
  assign bus.y_ovf        = ovf_q[1];

endmodule

// File: tb/tb_ps2_packet_decoder.sv
// Directed bench for ps2_packet_decoder with a shortened packet timeout.
module tb_ps2_packet_decoder;

  localparam int unsigned Timeout = 50;

  logic ck;
  logic reset;
  int   n_vec;
  int   n_miss;
  int   pv_cnt;
  int   fe_cnt;
  int   both_cnt;

  ps2_packet_decoder_if bus ();

  ps2_packet_decoder #(
    .PKT_TIMEOUT(Timeout),
    .TO_W       (18)
  ) u_dut (
    .ck   (ck),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Strobe counters sampled mid-cycle; each one-cycle strobe spans one negedge.
  always @(negedge ck) begin
    if (bus.packet_valid) pv_cnt++;
    if (bus.frame_err) fe_cnt++;
    if (bus.packet_valid && bus.frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Build a frame: start, D0..D7 (D0 at [9]), parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_start, input logic bad_stop);
    logic [10:0] f;
    f[10] = bad_start;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1] = ~(^b) ^ bad_par;
    f[0] = ~bad_stop;
    return f;
  endfunction

  task automatic send(input logic [10:0] f, input int hold);
    @(negedge ck);
    bus.data       = f;
    bus.word_ready = 1'b1;
    repeat (hold) @(negedge ck);
    bus.word_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    send(mk_frame(b, 1'b0, 1'b0, 1'b0), hold);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int hold);
    send_byte(b0, hold);
    send_byte(b1, hold);
    send_byte(b2, hold);
    repeat (2) @(negedge ck);
  endtask

  // {btn_middle, btn_right, btn_left, y_ovf, x_ovf}
  function automatic logic [4:0] flags();
    return {bus.btn_middle, bus.btn_right, bus.btn_left, bus.y_ovf, bus.x_ovf};
  endfunction

  function automatic logic [35:0] all_outs();
    return {3'b0, bus.packet_valid, bus.frame_err, bus.btn_left, bus.btn_right, bus.btn_middle,
            bus.dx, bus.dy, bus.x_ovf, bus.y_ovf, bus.err_cnt};
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge ck);
    reset = 1'b0;
    repeat (cycles) @(negedge ck);
    reset = 1'b1;
  endtask

  int p0;
  int f0;

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    pv_cnt         = 0;
    fe_cnt         = 0;
    both_cnt       = 0;
    reset          = 1'b0;
    bus.word_ready = 1'b0;
    bus.data       = '0;

    // Reset state, then idle with no frames.
    repeat (3) @(negedge ck);
    check("reset_outs", all_outs(), 36'd0);
    reset = 1'b1;
    repeat (5) @(negedge ck);
    check("idle_outs", all_outs(), 36'd0);
    check("idle_pv", 36'(pv_cnt), 36'd0);

    // Basic packet, single-cycle word_ready.
    p0 = pv_cnt;
    send_pkt(8'h29, 8'h05, 8'hFE, 1);
    check("pkt1_cnt", 36'(pv_cnt - p0), 36'd1);
    check("pkt1_flags", 36'(flags()), 36'(5'b00100));
    check("pkt1_dx", 36'(bus.dx), 36'h005);
    check("pkt1_dy", 36'(bus.dy), 36'h1FE);

    // Same packet with word_ready held 4 cycles per frame.
    p0 = pv_cnt;
    send_pkt(8'h29, 8'h05, 8'hFE, 4);
    check("pkt2_cnt", 36'(pv_cnt - p0), 36'd1);
    check("pkt2_dx_dy", {18'd0, bus.dx, bus.dy}, {18'd0, 9'h005, 9'h1FE});
    check("pkt2_flags", 36'(flags()), 36'(5'b00100));

    // Right+middle buttons, both overflows, positive dx/dy; outputs then hold.
    p0 = pv_cnt;
    send_pkt(8'hCE, 8'h80, 8'h7F, 1);
    check("pkt3_cnt", 36'(pv_cnt - p0), 36'd1);
    check("pkt3_flags", 36'(flags()), 36'(5'b11011));
    check("pkt3_dx_dy", {18'd0, bus.dx, bus.dy}, {18'd0, 9'h080, 9'h07F});
    repeat (10) @(negedge ck);
    check("pkt3_hold", {18'd0, bus.dx, bus.dy}, {18'd0, 9'h080, 9'h07F});

    // Bad parity on byte1, then a clean resend.
    p0 = pv_cnt;
    f0 = fe_cnt;
    send_byte(8'h09, 1);
    send(mk_frame(8'h03, 1'b1, 1'b0, 1'b0), 1);
    repeat (2) @(negedge ck);
    check("par_fe", 36'(fe_cnt - f0), 36'd1);
    check("par_errcnt", 36'(bus.err_cnt), 36'd1);
    check("par_no_pv", 36'(pv_cnt - p0), 36'd0);
    send_pkt(8'h09, 8'h03, 8'h04, 1);
    check("resend_cnt", 36'(pv_cnt - p0), 36'd1);
    check("resend_dx_dy", {18'd0, bus.dx, bus.dy}, {18'd0, 9'h003, 9'h004});

    // Byte0 without sync bit is rejected; next packet decodes from scratch.
    p0 = pv_cnt;
    f0 = fe_cnt;
    send_byte(8'h00, 1);
    repeat (2) @(negedge ck);
    check("sync_fe", 36'(fe_cnt - f0), 36'd1);
    check("sync_errcnt", 36'(bus.err_cnt), 36'd2);
    send_pkt(8'h08, 8'h01, 8'h01, 1);
    check("sync_pkt_cnt", 36'(pv_cnt - p0), 36'd1);
    check("sync_pkt", {13'd0, flags(), bus.dx, bus.dy}, {13'd0, 5'b00000, 9'h001, 9'h001});

    // Start bit high and stop bit low are each rejected.
    f0 = fe_cnt;
    send(mk_frame(8'h09, 1'b0, 1'b1, 1'b0), 1);
    send(mk_frame(8'h09, 1'b0, 1'b0, 1'b1), 1);
    repeat (2) @(negedge ck);
    check("startstop_fe", 36'(fe_cnt - f0), 36'd2);
    check("startstop_errcnt", 36'(bus.err_cnt), 36'd4);

    // Partial packet dropped after idle timeout, no frame_err.
    p0 = pv_cnt;
    f0 = fe_cnt;
    send_byte(8'h18, 1);
    send_byte(8'h10, 1);
    repeat (Timeout + 10) @(negedge ck);
    check("to_no_pv", 36'(pv_cnt - p0), 36'd0);
    send_pkt(8'h09, 8'h02, 8'h03, 1);
    check("to_pkt_cnt", 36'(pv_cnt - p0), 36'd1);
    check("to_pkt_dx_dy", {18'd0, bus.dx, bus.dy}, {18'd0, 9'h002, 9'h003});
    check("to_no_fe", 36'(fe_cnt - f0), 36'd0);

    // Error counter saturation.
    f0 = fe_cnt;
    for (int i = 0; i < 260; i++) send(mk_frame(8'h55, 1'b1, 1'b0, 1'b0), 1);
    repeat (2) @(negedge ck);
    check("sat_fe", 36'(fe_cnt - f0), 36'd260);
    check("sat_errcnt", 36'(bus.err_cnt), 36'd255);

    // Reset mid-packet: everything cleared, next three frames form a packet.
    send_byte(8'h09, 1);
    send_byte(8'h07, 1);
    do_reset(2);
    @(negedge ck);
    check("rst_outs", all_outs(), 36'd0);
    p0 = pv_cnt;
    send_pkt(8'h29, 8'h05, 8'hFE, 1);
    check("rst_pkt_cnt", 36'(pv_cnt - p0), 36'd1);
    check("rst_pkt", {13'd0, flags(), bus.dx, bus.dy}, {13'd0, 5'b00100, 9'h005, 9'h1FE});

    check("no_overlap", 36'(both_cnt), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
